// File: rtl/multiport_ram_2w2r_if.sv
// ---------------------------------------------------------------------------
// multiport_ram_2w2r_if
// Bus bundle for the 2-write / 2-read multiported RAM.
//   Write agent K (K=1,2): wrenK, wraddrK, wrdataK   (master -> slave)
//   Read agent J  (J=1,2): rdenJ, rdaddrJ            (master -> slave)
//                          rddataJ, rdcollisionJ     (slave  -> master)
//   rdcollisionJ[0] = write/write collision recorded for the read address
//   rdcollisionJ[1] = read hit an address being written in the same cycle
// ---------------------------------------------------------------------------
interface multiport_ram_2w2r_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic                  wren1;
    logic [ADDR_WIDTH-1:0] wraddr1;
    logic [DATA_WIDTH-1:0] wrdata1;
    logic                  wren2;
    logic [ADDR_WIDTH-1:0] wraddr2;
    logic [DATA_WIDTH-1:0] wrdata2;
    logic                  rden1;
    logic [ADDR_WIDTH-1:0] rdaddr1;
    logic [DATA_WIDTH-1:0] rddata1;
    logic [1:0]            rdcollision1;
    logic                  rden2;
    logic [ADDR_WIDTH-1:0] rdaddr2;
    logic [DATA_WIDTH-1:0] rddata2;
    logic [1:0]            rdcollision2;

    modport master (
        output wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2,
        output rden1, rdaddr1, rden2, rdaddr2,
        input  rddata1, rdcollision1, rddata2, rdcollision2
    );

    modport slave (
        input  wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2,
        input  rden1, rdaddr1, rden2, rdaddr2,
        output rddata1, rdcollision1, rddata2, rdcollision2
    );
endinterface

// File: rtl/multiport_ram_2w2r.sv
// ---------------------------------------------------------------------------
// multiport_ram_2w2r
// Two-write / two-read multiported synchronous RAM built from four simple
// dual-port banks (one per write agent per read agent) and a live-value
// table (LVT) that remembers which write agent last wrote each address.
// Ports:
//   aclk    - single clock
//   aresetn - asynchronous active-low reset (clears LVT and read outputs;
//             bank contents are not reset)
//   bus     - multiport_ram_2w2r_if.slave: write agents 1/2, read agents 1/2
// Reads are registered with latency 1 and are read-before-write.
// ---------------------------------------------------------------------------
module multiport_ram_2w2r #(
    parameter int ADDR_WIDTH      = 3,
    parameter int RAM_DEPTH       = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH      = 32,
    parameter int WRITE_COLLISION = 1,
    parameter int READ_COLLISION  = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    multiport_ram_2w2r_if.slave  bus
);

    // Elaboration-time parameter legality checks
    generate
        if ((WRITE_COLLISION != 32'sd0) && (WRITE_COLLISION != 32'sd1)) begin : g_bad_wc
            $error("multiport_ram_2w2r: WRITE_COLLISION must be 0 or 1");
        end
        if ((READ_COLLISION != 32'sd0) && (READ_COLLISION != 32'sd1)) begin : g_bad_rc
            $error("multiport_ram_2w2r: READ_COLLISION must be 0 or 1");
        end
        if (RAM_DEPTH > (2**ADDR_WIDTH)) begin : g_bad_depth
            $error("multiport_ram_2w2r: RAM_DEPTH must not exceed 2**ADDR_WIDTH");
        end
    endgenerate

    localparam logic                WR_COL_EN = (WRITE_COLLISION == 32'sd1);
    localparam logic                RD_COL_EN = (READ_COLLISION == 32'sd1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = RAM_DEPTH[ADDR_WIDTH:0];

    // True when the address maps onto a physical word
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM);
    endfunction

    // Banks: r_bankK_pJ is written by agent K and read only by read port J
    logic [DATA_WIDTH-1:0] r_bank1_p1 [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_bank1_p2 [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_bank2_p1 [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_bank2_p2 [RAM_DEPTH];

    // LVT: select bit (0 = agent 1, 1 = agent 2) and collision bit per word
    logic [RAM_DEPTH-1:0]  r_lvt_sel;
    logic [RAM_DEPTH-1:0]  r_lvt_col;

    logic [DATA_WIDTH-1:0] r_rddata1;
    logic [DATA_WIDTH-1:0] r_rddata2;
    logic [1:0]            r_rdcol1;
    logic [1:0]            r_rdcol2;

    logic                  w_wr1_ok;
    logic                  w_wr2_ok;
    logic                  w_wr_same;
    logic                  w_rdcol1;
    logic                  w_rdcol2;

    // Qualified write strobes and write/write same-address detect
    always_comb begin
        w_wr1_ok  = bus.wren1 & f_in_range(bus.wraddr1);
        w_wr2_ok  = bus.wren2 & f_in_range(bus.wraddr2);
        w_wr_same = w_wr1_ok & w_wr2_ok & (bus.wraddr1 == bus.wraddr2);
    end

    // Read/write same-cycle detect for each read port
    always_comb begin
        w_rdcol1 = 1'b0;
        w_rdcol2 = 1'b0;
        if (RD_COL_EN) begin
            w_rdcol1 = (bus.wren1 & (bus.wraddr1 == bus.rdaddr1)) |
                       (bus.wren2 & (bus.wraddr2 == bus.rdaddr1));
            w_rdcol2 = (bus.wren1 & (bus.wraddr1 == bus.rdaddr2)) |
                       (bus.wren2 & (bus.wraddr2 == bus.rdaddr2));
        end else begin
            w_rdcol1 = 1'b0;
            w_rdcol2 = 1'b0;
        end
    end

    // Bank write ports; no reset so these map onto block RAM
    always_ff @(posedge aclk) begin
        if (w_wr1_ok) begin
            r_bank1_p1[bus.wraddr1] <= bus.wrdata1;
            r_bank1_p2[bus.wraddr1] <= bus.wrdata1;
        end
        if (w_wr2_ok) begin
            r_bank2_p1[bus.wraddr2] <= bus.wrdata2;
            r_bank2_p2[bus.wraddr2] <= bus.wrdata2;
        end
    end

    // LVT update; on a same-address collision agent 1 owns the word
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lvt_sel <= {RAM_DEPTH{1'b0}};
            r_lvt_col <= {RAM_DEPTH{1'b0}};
        end else if (w_wr_same) begin
            r_lvt_sel[bus.wraddr1] <= 1'b0;
            r_lvt_col[bus.wraddr1] <= WR_COL_EN;
        end else begin
            if (w_wr1_ok) begin
                r_lvt_sel[bus.wraddr1] <= 1'b0;
                r_lvt_col[bus.wraddr1] <= 1'b0;
            end
            if (w_wr2_ok) begin
                r_lvt_sel[bus.wraddr2] <= 1'b1;
                r_lvt_col[bus.wraddr2] <= 1'b0;
            end
        end
    end

    // Read port 1: bank data and LVT sampled on the same edge (old values)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rddata1 <= {DATA_WIDTH{1'b0}};
            r_rdcol1  <= 2'b00;
        end else if (bus.rden1) begin
            r_rddata1 <= r_lvt_sel[bus.rdaddr1] ? r_bank2_p1[bus.rdaddr1]
                                                : r_bank1_p1[bus.rdaddr1];
            r_rdcol1  <= {w_rdcol1, r_lvt_col[bus.rdaddr1]};
        end
    end

    // Read port 2: same structure as port 1 on its own bank replicas
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rddata2 <= {DATA_WIDTH{1'b0}};
            r_rdcol2  <= 2'b00;
        end else if (bus.rden2) begin
            r_rddata2 <= r_lvt_sel[bus.rdaddr2] ? r_bank2_p2[bus.rdaddr2]
                                                : r_bank1_p2[bus.rdaddr2];
            r_rdcol2  <= {w_rdcol2, r_lvt_col[bus.rdaddr2]};
        end
    end

    assign bus.rddata1      = r_rddata1;
    assign bus.rdcollision1 = r_rdcol1;
    assign bus.rddata2      = r_rddata2;
    assign bus.rdcollision2 = r_rdcol2;

endmodule

// File: tb/tb_multiport_ram_2w2r.sv
// ---------------------------------------------------------------------------
// tb_multiport_ram_2w2r
// Directed, table-driven bench for multiport_ram_2w2r. Each vector is one
// clock cycle of stimulus plus the read-port values expected right after
// that cycle's rising edge.
// ---------------------------------------------------------------------------
module tb_multiport_ram_2w2r;

    logic aclk;
    logic aresetn;

    multiport_ram_2w2r_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus ();

    multiport_ram_2w2r #(
        .ADDR_WIDTH      (3),
        .RAM_DEPTH       (8),
        .DATA_WIDTH      (32),
        .WRITE_COLLISION (1),
        .READ_COLLISION  (1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        w1;
        logic [2:0]  a1;
        logic [31:0] d1;
        logic        w2;
        logic [2:0]  a2;
        logic [31:0] d2;
        logic        r1;
        logic [2:0]  ra1;
        logic        r2;
        logic [2:0]  ra2;
        logic        c1;
        logic [31:0] e1;
        logic [1:0]  ec1;
        logic        c2;
        logic [31:0] e2;
        logic [1:0]  ec2;
    } vec_t;

    vec_t vecs [21];
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wren1 = 1'b0; bus.wraddr1 = 3'd0; bus.wrdata1 = 32'h0;
        bus.wren2 = 1'b0; bus.wraddr2 = 3'd0; bus.wrdata2 = 32'h0;
        bus.rden1 = 1'b0; bus.rdaddr1 = 3'd0;
        bus.rden2 = 1'b0; bus.rdaddr2 = 3'd0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge aclk);
        bus.wren1 = v.w1; bus.wraddr1 = v.a1; bus.wrdata1 = v.d1;
        bus.wren2 = v.w2; bus.wraddr2 = v.a2; bus.wrdata2 = v.d2;
        bus.rden1 = v.r1; bus.rdaddr1 = v.ra1;
        bus.rden2 = v.r2; bus.rdaddr2 = v.ra2;
        @(posedge aclk);
        #1;
        if (v.c1) begin
            check({tag, " rddata1"}, bus.rddata1, v.e1);
            check({tag, " rdcollision1"}, {30'd0, bus.rdcollision1}, {30'd0, v.ec1});
        end
        if (v.c2) begin
            check({tag, " rddata2"}, bus.rddata2, v.e2);
            check({tag, " rdcollision2"}, {30'd0, bus.rdcollision2}, {30'd0, v.ec2});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Fields: w1,a1,d1, w2,a2,d2, r1,ra1, r2,ra2, c1,e1,ec1, c2,e2,ec2
        vecs[0]  = '{1'b1,3'd2,32'hAAAA0001, 1'b0,3'd0,32'h0, 1'b0,3'd0, 1'b0,3'd0, 1'b1,32'h0,2'b00, 1'b1,32'h0,2'b00};
        vecs[1]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd2, 1'b0,3'd0, 1'b1,32'hAAAA0001,2'b00, 1'b1,32'h0,2'b00};
        vecs[2]  = '{1'b0,3'd0,32'h0, 1'b1,3'd2,32'hBBBB0002, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[3]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd2, 1'b1,3'd2, 1'b1,32'hBBBB0002,2'b00, 1'b1,32'hBBBB0002,2'b00};
        vecs[4]  = '{1'b1,3'd2,32'h11, 1'b0,3'd0,32'h0, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[5]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd2, 1'b1,3'd2, 1'b1,32'h11,2'b00, 1'b1,32'h11,2'b00};
        vecs[6]  = '{1'b1,3'd0,32'h10, 1'b1,3'd7,32'h70, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[7]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd0, 1'b1,3'd7, 1'b1,32'h10,2'b00, 1'b1,32'h70,2'b00};
        vecs[8]  = '{1'b1,3'd5,32'h55, 1'b1,3'd5,32'h66, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[9]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd5, 1'b1,3'd5, 1'b1,32'h55,2'b01, 1'b1,32'h55,2'b01};
        vecs[10] = '{1'b0,3'd0,32'h0, 1'b1,3'd5,32'h77, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[11] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd5, 1'b1,3'd5, 1'b1,32'h77,2'b00, 1'b1,32'h77,2'b00};
        vecs[12] = '{1'b1,3'd3,32'h33, 1'b0,3'd0,32'h0, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[13] = '{1'b1,3'd3,32'h44, 1'b0,3'd0,32'h0, 1'b1,3'd3, 1'b1,3'd5, 1'b1,32'h33,2'b10, 1'b1,32'h77,2'b00};
        vecs[14] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd3, 1'b0,3'd0, 1'b1,32'h44,2'b00, 1'b1,32'h77,2'b00};
        vecs[15] = '{1'b0,3'd0,32'h0, 1'b1,3'd0,32'h20, 1'b1,3'd7, 1'b1,3'd0, 1'b1,32'h70,2'b00, 1'b1,32'h10,2'b10};
        vecs[16] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b0,3'd0, 1'b1,3'd0, 1'b1,32'h70,2'b00, 1'b1,32'h20,2'b00};
        vecs[17] = '{1'b1,3'd6,32'h61, 1'b1,3'd6,32'h62, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[18] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd6, 1'b1,3'd6, 1'b1,32'h61,2'b01, 1'b1,32'h61,2'b01};
        vecs[19] = '{1'b1,3'd6,32'h63, 1'b0,3'd0,32'h0, 1'b0,3'd0, 1'b0,3'd0, 1'b0,32'h0,2'b00, 1'b0,32'h0,2'b00};
        vecs[20] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd6, 1'b0,3'd0, 1'b1,32'h63,2'b00, 1'b1,32'h61,2'b01};

        // Reset
        drive_idle();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset rddata1", bus.rddata1, 32'h0);
        check("reset rdcollision1", {30'd0, bus.rdcollision1}, 32'h0);
        check("reset rddata2", bus.rddata2, 32'h0);
        check("reset rdcollision2", {30'd0, bus.rdcollision2}, 32'h0);
        aresetn = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold: read enables low for three cycles while unrelated writes run
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            drive_idle();
            bus.wren1 = 1'b1; bus.wraddr1 = 3'd1; bus.wrdata1 = 32'h1111 + k;
            bus.wren2 = 1'b1; bus.wraddr2 = 3'd4; bus.wrdata2 = 32'h4444 + k;
            @(posedge aclk);
            #1;
            check("hold rddata1", bus.rddata1, 32'h63);
            check("hold rdcollision1", {30'd0, bus.rdcollision1}, 32'h0);
            check("hold rddata2", bus.rddata2, 32'h61);
            check("hold rdcollision2", {30'd0, bus.rdcollision2}, 32'h1);
        end

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        @(negedge aclk);
        drive_idle();
        #2;
        aresetn = 1'b0;
        #1;
        check("async rst rddata1", bus.rddata1, 32'h0);
        check("async rst rdcollision1", {30'd0, bus.rdcollision1}, 32'h0);
        check("async rst rddata2", bus.rddata2, 32'h0);
        check("async rst rdcollision2", {30'd0, bus.rdcollision2}, 32'h0);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        // LVT cleared by reset: every word now steered to agent 1's banks,
        // which still hold agent 1's last data (0x55 at 5, 0x10 at 0)
        apply('{1'b0,3'd0,32'h0, 1'b0,3'd0,32'h0, 1'b1,3'd5, 1'b1,3'd0,
                1'b1,32'h55,2'b00, 1'b1,32'h10,2'b00}, "post-reset lvt");

        drive_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
